// File: rtl/dmem_bridge.sv
// Data-memory bridge: turns the core's level-held load/store request into a
// single-outstanding valid/ready bus transaction and returns a one-cycle
// completion pulse. Misaligned accesses and dead-bus timeouts complete with
// core_err set, so retire can never hang on the memory port.
module dmem_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned ADDR_W         = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              core_wr_en,
  input  logic              core_rd_en,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [31:0]       core_wdata,
  output logic              core_valid,
  output logic [31:0]       core_rdata,
  output logic              core_err,
  output logic              bus_req_valid,
  input  logic              bus_req_ready,
  output logic              bus_req_we,
  output logic [ADDR_W-1:0] bus_req_addr,
  output logic [31:0]       bus_req_wdata,
  input  logic              bus_resp_valid,
  input  logic [31:0]       bus_resp_rdata
);

  typedef enum logic [1:0] {StIdle, StReq, StWait, StDone} state_e;

  // One extra bit so the incremented count can be compared without wrapping.
  localparam logic [16:0] TimeoutLimit = 17'(TIMEOUT_CYCLES);

  state_e            state_q, state_d;
  logic [15:0]       cnt_q, cnt_d;
  logic [16:0]       cnt_inc;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              req_valid_q, req_valid_d;
  logic              core_valid_q, core_valid_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;

  assign cnt_inc = {1'b0, cnt_q} + 17'd1;

  // Next-state and registered-output logic; completion outputs default to 0
  // so they are high only in the single DONE cycle.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    req_valid_d  = req_valid_q;
    core_valid_d = 1'b0;
    rdata_d      = 32'h0;
    err_d        = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (core_wr_en || core_rd_en) begin
          we_d    = core_wr_en;
          addr_d  = {core_addr[ADDR_W-1:2], 2'b00};
          wdata_d = core_wdata;
          if (core_addr[1:0] != 2'b00) begin
            // Misaligned: complete with error, never touch the bus.
            state_d      = StDone;
            core_valid_d = 1'b1;
            err_d        = 1'b1;
          end else begin
            state_d     = StReq;
            req_valid_d = 1'b1;
            cnt_d       = 16'h0;
          end
        end
      end

      StReq: begin
        cnt_d = cnt_inc[15:0];
        if (cnt_inc == TimeoutLimit) begin
          state_d      = StDone;
          req_valid_d  = 1'b0;
          core_valid_d = 1'b1;
          err_d        = 1'b1;
        end else if (bus_req_ready) begin
          state_d     = StWait;
          req_valid_d = 1'b0;
        end
      end

      StWait: begin
        cnt_d = cnt_inc[15:0];
        // A response landing in the final cycle still counts as a success.
        if (bus_resp_valid) begin
          state_d      = StDone;
          core_valid_d = 1'b1;
          rdata_d      = we_q ? 32'h0 : bus_resp_rdata;
        end else if (cnt_inc == TimeoutLimit) begin
          state_d      = StDone;
          core_valid_d = 1'b1;
          err_d        = 1'b1;
        end
      end

      StDone: begin
        // Request levels are deliberately not sampled here.
        state_d = StIdle;
      end

      default: begin
        state_d     = StIdle;
        req_valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      cnt_q        <= 16'h0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= 32'h0;
      req_valid_q  <= 1'b0;
      core_valid_q <= 1'b0;
      rdata_q      <= 32'h0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      req_valid_q  <= req_valid_d;
      core_valid_q <= core_valid_d;
      rdata_q      <= rdata_d;
      err_q        <= err_d;
    end
  end

  assign core_valid    = core_valid_q;
  assign core_rdata    = rdata_q;
  assign core_err      = err_q;
  assign bus_req_valid = req_valid_q;
  assign bus_req_we    = we_q;
  assign bus_req_addr  = addr_q;
  assign bus_req_wdata = wdata_q;

endmodule

// File: tb/tb_dmem_bridge.sv
// Directed bench for dmem_bridge with a short timeout (8 cycles).
module tb_dmem_bridge;

  logic        clk;
  logic        rst;
  logic        core_wr_en;
  logic        core_rd_en;
  logic [31:0] core_addr;
  logic [31:0] core_wdata;
  logic        core_valid;
  logic [31:0] core_rdata;
  logic        core_err;
  logic        bus_req_valid;
  logic        bus_req_ready;
  logic        bus_req_we;
  logic [31:0] bus_req_addr;
  logic [31:0] bus_req_wdata;
  logic        bus_resp_valid;
  logic [31:0] bus_resp_rdata;

  int passed = 0;
  int total  = 0;
  int accepts = 0;
  int acc0;

  dmem_bridge #(
    .TIMEOUT_CYCLES(8),
    .ADDR_W        (32)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .core_wr_en    (core_wr_en),
    .core_rd_en    (core_rd_en),
    .core_addr     (core_addr),
    .core_wdata    (core_wdata),
    .core_valid    (core_valid),
    .core_rdata    (core_rdata),
    .core_err      (core_err),
    .bus_req_valid (bus_req_valid),
    .bus_req_ready (bus_req_ready),
    .bus_req_we    (bus_req_we),
    .bus_req_addr  (bus_req_addr),
    .bus_req_wdata (bus_req_wdata),
    .bus_resp_valid(bus_resp_valid),
    .bus_resp_rdata(bus_resp_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count accepted bus requests.
  always @(posedge clk) begin
    if (!rst && bus_req_valid && bus_req_ready) accepts <= accepts + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, " core_valid"}, {31'h0, core_valid}, 32'h0);
    chk({tag, " core_rdata"}, core_rdata, 32'h0);
    chk({tag, " core_err"}, {31'h0, core_err}, 32'h0);
    chk({tag, " req_valid"}, {31'h0, bus_req_valid}, 32'h0);
  endtask

  initial begin
    rst = 1'b1;
    core_wr_en = 1'b0;
    core_rd_en = 1'b0;
    core_addr = 32'h0;
    core_wdata = 32'h0;
    bus_req_ready = 1'b0;
    bus_resp_valid = 1'b0;
    bus_resp_rdata = 32'h0;
    tick();
    tick();

    // Reset state
    chk_idle_outputs("reset");
    chk("reset req_we", {31'h0, bus_req_we}, 32'h0);
    chk("reset req_addr", bus_req_addr, 32'h0);
    chk("reset req_wdata", bus_req_wdata, 32'h0);
    rst = 1'b0;
    tick();

    // Aligned read, zero-wait bus
    core_rd_en = 1'b1;
    core_addr  = 32'h100;
    tick();  // cycle 1
    chk("rd c1 req_valid", {31'h0, bus_req_valid}, 32'h1);
    chk("rd c1 req_we", {31'h0, bus_req_we}, 32'h0);
    chk("rd c1 req_addr", bus_req_addr, 32'h100);
    chk("rd c1 core_valid", {31'h0, core_valid}, 32'h0);
    bus_req_ready = 1'b1;
    tick();  // cycle 2
    chk("rd c2 req_valid", {31'h0, bus_req_valid}, 32'h0);
    chk("rd c2 core_valid", {31'h0, core_valid}, 32'h0);
    bus_req_ready  = 1'b0;
    bus_resp_valid = 1'b1;
    bus_resp_rdata = 32'hDEADBEEF;
    tick();  // cycle 3
    chk("rd c3 core_valid", {31'h0, core_valid}, 32'h1);
    chk("rd c3 core_rdata", core_rdata, 32'hDEADBEEF);
    chk("rd c3 core_err", {31'h0, core_err}, 32'h0);
    bus_resp_valid = 1'b0;
    core_rd_en     = 1'b0;
    tick();  // cycle 4
    chk_idle_outputs("rd c4");
    chk("rd accepts", accepts, 32'd1);

    // Write with 4 cycles of backpressure
    core_wr_en = 1'b1;
    core_addr  = 32'h204;
    core_wdata = 32'h12345678;
    for (int i = 0; i < 5; i++) begin
      tick();  // cycles 1..5
      chk("wr req_valid", {31'h0, bus_req_valid}, 32'h1);
      chk("wr req_we", {31'h0, bus_req_we}, 32'h1);
      chk("wr req_addr", bus_req_addr, 32'h204);
      chk("wr req_wdata", bus_req_wdata, 32'h12345678);
      chk("wr core_valid", {31'h0, core_valid}, 32'h0);
      if (i == 4) bus_req_ready = 1'b1;
    end
    tick();  // cycle 6
    chk("wr c6 req_valid", {31'h0, bus_req_valid}, 32'h0);
    bus_req_ready  = 1'b0;
    bus_resp_valid = 1'b1;
    bus_resp_rdata = 32'hCAFEF00D;
    tick();  // cycle 7
    chk("wr c7 core_valid", {31'h0, core_valid}, 32'h1);
    chk("wr c7 core_rdata", core_rdata, 32'h0);
    chk("wr c7 core_err", {31'h0, core_err}, 32'h0);
    bus_resp_valid = 1'b0;
    core_wr_en     = 1'b0;
    tick();
    chk_idle_outputs("wr after");
    chk("wr accepts", accepts, 32'd2);

    // Misaligned read: error completion without a bus request
    core_rd_en = 1'b1;
    core_addr  = 32'h102;
    tick();  // cycle 1
    chk("mis c1 core_valid", {31'h0, core_valid}, 32'h1);
    chk("mis c1 core_err", {31'h0, core_err}, 32'h1);
    chk("mis c1 core_rdata", core_rdata, 32'h0);
    chk("mis c1 req_valid", {31'h0, bus_req_valid}, 32'h0);
    core_rd_en = 1'b0;
    tick();
    chk_idle_outputs("mis c2");
    chk("mis accepts", accepts, 32'd2);

    // Timeout: read accepted, response never arrives
    core_rd_en = 1'b1;
    core_addr  = 32'h300;
    tick();  // cycle 1 (REQ)
    chk("to c1 req_valid", {31'h0, bus_req_valid}, 32'h1);
    bus_req_ready = 1'b1;
    tick();  // cycle 2 (WAIT)
    bus_req_ready = 1'b0;
    chk("to c2 req_valid", {31'h0, bus_req_valid}, 32'h0);
    for (int i = 3; i <= 8; i++) begin
      tick();
      chk("to wait core_valid", {31'h0, core_valid}, 32'h0);
    end
    tick();  // cycle 9: 8 REQ+WAIT cycles elapsed
    chk("to c9 core_valid", {31'h0, core_valid}, 32'h1);
    chk("to c9 core_err", {31'h0, core_err}, 32'h1);
    chk("to c9 core_rdata", core_rdata, 32'h0);
    core_rd_en = 1'b0;
    tick();
    chk_idle_outputs("to c10");
    bus_resp_valid = 1'b1;
    bus_resp_rdata = 32'h00000055;
    tick();
    chk("to late core_valid", {31'h0, core_valid}, 32'h0);
    chk("to late req_valid", {31'h0, bus_req_valid}, 32'h0);
    bus_resp_valid = 1'b0;
    tick();
    chk("to late2 core_valid", {31'h0, core_valid}, 32'h0);

    // Simultaneous enables, held past core_valid
    acc0 = accepts;
    core_wr_en = 1'b1;
    core_rd_en = 1'b1;
    core_addr  = 32'h40;
    core_wdata = 32'hA5A5A5A5;
    tick();  // cycle 1
    chk("both c1 req_we", {31'h0, bus_req_we}, 32'h1);
    chk("both c1 req_addr", bus_req_addr, 32'h40);
    chk("both c1 req_wdata", bus_req_wdata, 32'hA5A5A5A5);
    bus_req_ready = 1'b1;
    tick();  // cycle 2
    bus_req_ready  = 1'b0;
    bus_resp_valid = 1'b1;
    bus_resp_rdata = 32'h11111111;
    tick();  // cycle 3, enables still held through the next edge
    chk("both c3 core_valid", {31'h0, core_valid}, 32'h1);
    chk("both c3 core_rdata", core_rdata, 32'h0);
    bus_resp_valid = 1'b0;
    tick();  // cycle 4
    core_wr_en = 1'b0;
    core_rd_en = 1'b0;
    chk_idle_outputs("both c4");
    tick();
    chk_idle_outputs("both c5");
    tick();
    chk_idle_outputs("both c6");
    chk("both accepts", accepts - acc0, 32'd1);

    // Reset in WAIT, then a stray response
    core_rd_en = 1'b1;
    core_addr  = 32'h80;
    tick();
    bus_req_ready = 1'b1;
    tick();  // WAIT
    bus_req_ready = 1'b0;
    rst = 1'b1;
    tick();
    chk_idle_outputs("rst");
    chk("rst req_we", {31'h0, bus_req_we}, 32'h0);
    chk("rst req_addr", bus_req_addr, 32'h0);
    rst = 1'b0;
    core_rd_en = 1'b0;
    bus_resp_valid = 1'b1;
    bus_resp_rdata = 32'h00000077;
    tick();
    chk("rst stray core_valid", {31'h0, core_valid}, 32'h0);
    bus_resp_valid = 1'b0;
    tick();
    chk("rst stray2 core_valid", {31'h0, core_valid}, 32'h0);

    // Normal read after reset
    core_rd_en = 1'b1;
    core_addr  = 32'h104;
    tick();
    chk("post c1 req_addr", bus_req_addr, 32'h104);
    chk("post c1 req_valid", {31'h0, bus_req_valid}, 32'h1);
    bus_req_ready = 1'b1;
    tick();
    bus_req_ready  = 1'b0;
    bus_resp_valid = 1'b1;
    bus_resp_rdata = 32'h0BADF00D;
    tick();
    chk("post c3 core_valid", {31'h0, core_valid}, 32'h1);
    chk("post c3 core_rdata", core_rdata, 32'h0BADF00D);
    chk("post c3 core_err", {31'h0, core_err}, 32'h0);
    bus_resp_valid = 1'b0;
    core_rd_en     = 1'b0;
    tick();
    chk_idle_outputs("post c4");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
